// File: rtl/fs_dither_ctrl.sv
// Purpose : frame sequencer for gray pass plus optional FS-diffusion or threshold pass.
// Latency : first strobe one cycle after start is taken; done the cycle after the last write.
// Backpressure: none; a frame runs to completion and start is ignored while busy.
//
// Ports:
//   clk, rst (async active-low)      - clock and reset
//   start, mode[1:0]                 - frame request and pass select (taken in IDLE only)
//   en_in_mem, in_mem_addr           - input memory read
//   en_gray                          - grayscale unit enable
//   en_out_mem, out_mem_read/write,
//   out_mem_addr, mux_sel            - output memory access and write-data select
//   en_err_dif, err_dif_addr[2:0]    - diffusion compute enable and neighbour slot code
//   busy, done                       - frame status (done held until the next start)
module fs_dither_ctrl #(
  parameter int IMG_W  = 1024,
  parameter int IMG_H  = 768,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              en_in_mem,
  output logic [ADDR_W-1:0] in_mem_addr,
  output logic              en_gray,
  output logic              mux_sel,
  output logic              en_out_mem,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              en_err_dif,
  output logic [2:0]        err_dif_addr,
  output logic              busy,
  output logic              done
);

  localparam int N  = IMG_W * IMG_H;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  localparam logic [2:0] SLOT_C  = 3'd0;
  localparam logic [2:0] SLOT_R  = 3'd1;
  localparam logic [2:0] SLOT_LL = 3'd2;
  localparam logic [2:0] SLOT_LC = 3'd3;
  localparam logic [2:0] SLOT_LR = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_G_RD, S_G_CALC, S_G_WB, S_F_RD, S_F_ERR, S_F_WB, S_DONE
  } state_t;

  // Current-cycle sequencing state; output registers always mirror it.
  state_t            state, nxt_state;
  logic [XW-1:0]     x, nxt_x;
  logic [YW-1:0]     y, nxt_y;
  logic [ADDR_W-1:0] p, nxt_p;
  logic [2:0]        slot, nxt_slot;
  logic              do_ph2, nxt_do_ph2;
  logic              do_fs, nxt_do_fs;

  logic              last_x, last_y, last_p;
  logic [4:0]        slot_mask;
  logic              has_next;
  logic [2:0]        next_slot;
  logic [XW-1:0]     px_x;
  logic [YW-1:0]     px_y;

  logic              nxt_en_in_mem, nxt_en_gray, nxt_mux_sel, nxt_en_out_mem;
  logic              nxt_out_mem_read, nxt_out_mem_write, nxt_en_err_dif;
  logic              nxt_busy, nxt_done;
  logic [ADDR_W-1:0] nxt_in_mem_addr, nxt_out_mem_addr, nxt_slot_addr;
  logic [2:0]        nxt_err_dif_addr;

  assign last_x = (x == XW'(IMG_W - 1));
  assign last_y = (y == YW'(IMG_H - 1));
  assign last_p = (p == ADDR_W'(N - 1));

  // Neighbours that fall outside the image are dropped from the slot list.
  // Threshold mode only ever visits the centre slot.
  always_comb begin
    slot_mask    = 5'b00001;
    slot_mask[1] = do_fs & ~last_x;
    slot_mask[2] = do_fs & (x != '0) & ~last_y;
    slot_mask[3] = do_fs & ~last_y;
    slot_mask[4] = do_fs & ~last_x & ~last_y;
  end

  // First active slot after the current one; descending scan leaves the lowest match.
  always_comb begin
    has_next  = 1'b0;
    next_slot = slot;
    for (int i = 4; i >= 1; i--) begin
      if (slot_mask[i] && (3'(i) > slot)) begin
        has_next  = 1'b1;
        next_slot = 3'(i);
      end
    end
  end

  // Raster advance: x wraps to 0 and y steps, so no multiply is needed for p.
  always_comb begin
    if (last_x) begin
      px_x = '0;
      px_y = y + 1'b1;
    end else begin
      px_x = x + 1'b1;
      px_y = y;
    end
  end

  always_comb begin
    nxt_state  = state;
    nxt_x      = x;
    nxt_y      = y;
    nxt_p      = p;
    nxt_slot   = slot;
    nxt_do_ph2 = do_ph2;
    nxt_do_fs  = do_fs;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state  = S_G_RD;
          nxt_x      = '0;
          nxt_y      = '0;
          nxt_p      = '0;
          nxt_slot   = SLOT_C;
          nxt_do_ph2 = (mode == 2'd1) || (mode == 2'd2);
          nxt_do_fs  = (mode == 2'd1);
        end
      end
      S_G_RD:   nxt_state = S_G_CALC;
      S_G_CALC: nxt_state = S_G_WB;
      S_G_WB: begin
        if (last_p) begin
          if (do_ph2) begin
            nxt_state = S_F_RD;
            nxt_x     = '0;
            nxt_y     = '0;
            nxt_p     = '0;
            nxt_slot  = SLOT_C;
          end else begin
            nxt_state = S_DONE;
          end
        end else begin
          nxt_state = S_G_RD;
          nxt_x     = px_x;
          nxt_y     = px_y;
          nxt_p     = p + 1'b1;
        end
      end
      S_F_RD: begin
        if (has_next) begin
          nxt_slot = next_slot;
        end else begin
          nxt_state = S_F_ERR;
          nxt_slot  = SLOT_C;
        end
      end
      S_F_ERR:  nxt_state = S_F_WB;
      S_F_WB: begin
        if (has_next) begin
          nxt_slot = next_slot;
        end else if (last_p) begin
          nxt_state = S_DONE;
        end else begin
          nxt_state = S_F_RD;
          nxt_slot  = SLOT_C;
          nxt_x     = px_x;
          nxt_y     = px_y;
          nxt_p     = p + 1'b1;
        end
      end
      S_DONE:   nxt_state = S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase
  end

  always_comb begin
    case (nxt_slot)
      SLOT_R:  nxt_slot_addr = nxt_p + 1'b1;
      SLOT_LL: nxt_slot_addr = nxt_p + ADDR_W'(IMG_W - 1);
      SLOT_LC: nxt_slot_addr = nxt_p + ADDR_W'(IMG_W);
      SLOT_LR: nxt_slot_addr = nxt_p + ADDR_W'(IMG_W + 1);
      default: nxt_slot_addr = nxt_p;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with the state register in the cycle they describe.
  always_comb begin
    nxt_en_in_mem     = 1'b0;
    nxt_in_mem_addr   = '0;
    nxt_en_gray       = 1'b0;
    nxt_mux_sel       = 1'b0;
    nxt_en_out_mem    = 1'b0;
    nxt_out_mem_read  = 1'b0;
    nxt_out_mem_write = 1'b0;
    nxt_out_mem_addr  = '0;
    nxt_en_err_dif    = 1'b0;
    nxt_err_dif_addr  = SLOT_C;
    case (nxt_state)
      S_G_RD: begin
        nxt_en_in_mem   = 1'b1;
        nxt_in_mem_addr = nxt_p;
      end
      S_G_CALC: nxt_en_gray = 1'b1;
      S_G_WB: begin
        nxt_en_out_mem    = 1'b1;
        nxt_out_mem_write = 1'b1;
        nxt_out_mem_addr  = nxt_p;
      end
      S_F_RD: begin
        nxt_en_out_mem   = 1'b1;
        nxt_out_mem_read = 1'b1;
        nxt_out_mem_addr = nxt_slot_addr;
        nxt_err_dif_addr = nxt_slot;
      end
      S_F_ERR: nxt_en_err_dif = 1'b1;
      S_F_WB: begin
        nxt_en_out_mem    = 1'b1;
        nxt_out_mem_write = 1'b1;
        nxt_mux_sel       = 1'b1;
        nxt_out_mem_addr  = nxt_slot_addr;
        nxt_err_dif_addr  = nxt_slot;
      end
      default: ;
    endcase
    nxt_busy = (nxt_state != S_IDLE) && (nxt_state != S_DONE);
    // done stays up through IDLE and drops only when a start is taken.
    nxt_done = (nxt_state == S_DONE) || (done && (nxt_state == S_IDLE));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      p             <= '0;
      slot          <= SLOT_C;
      do_ph2        <= 1'b0;
      do_fs         <= 1'b0;
      en_in_mem     <= 1'b0;
      in_mem_addr   <= '0;
      en_gray       <= 1'b0;
      mux_sel       <= 1'b0;
      en_out_mem    <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      out_mem_addr  <= '0;
      en_err_dif    <= 1'b0;
      err_dif_addr  <= SLOT_C;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= nxt_state;
      x             <= nxt_x;
      y             <= nxt_y;
      p             <= nxt_p;
      slot          <= nxt_slot;
      do_ph2        <= nxt_do_ph2;
      do_fs         <= nxt_do_fs;
      en_in_mem     <= nxt_en_in_mem;
      in_mem_addr   <= nxt_in_mem_addr;
      en_gray       <= nxt_en_gray;
      mux_sel       <= nxt_mux_sel;
      en_out_mem    <= nxt_en_out_mem;
      out_mem_read  <= nxt_out_mem_read;
      out_mem_write <= nxt_out_mem_write;
      out_mem_addr  <= nxt_out_mem_addr;
      en_err_dif    <= nxt_en_err_dif;
      err_dif_addr  <= nxt_err_dif_addr;
      busy          <= nxt_busy;
      done          <= nxt_done;
    end
  end

endmodule
